// File: rtl/proc_sequencer.sv
// proc_sequencer: multicycle control FSM for the 9-bit processor datapath.
// Owns the step counter (Tstep) and the instruction register (IR). Every
// datapath enable is decoded combinationally from the current step, the
// instruction fields, G_nz, Run and Reset.
module proc_sequencer #(
  parameter int N      = 9,
  parameter int PC_IDX = 7
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Run,
  input  logic [N-1:0] DIN,
  input  logic         G_nz,
  output logic         IRin,
  output logic [7:0]   Rin,
  output logic [7:0]   Rout,
  output logic         Ain,
  output logic         Gin,
  output logic         Gout,
  output logic         AddSub,
  output logic         DINout,
  output logic         ADDRin,
  output logic         DOUTin,
  output logic         incr_pc,
  output logic         W_D,
  output logic         Done,
  output logic [2:0]   Tstep,
  output logic [N-1:0] IR
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
  } step_e;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_NOP  = 3'b111
  } opcode_e;

  localparam logic [2:0] PC_SEL = 3'(PC_IDX);

  step_e        tstep_q, tstep_d;
  logic [N-1:0] ir_q, ir_d;
  opcode_e      opcode;
  logic [2:0]   rx, ry;
  logic         active;

  assign opcode = opcode_e'(ir_q[2:0]);
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[8:6];
  assign active = Run && !Reset;
  assign Tstep  = tstep_q;
  assign IR     = ir_q;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  // Decode the datapath enables for the current step and instruction.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    IRin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    AddSub  = 1'b0;
    DINout  = 1'b0;
    ADDRin  = 1'b0;
    DOUTin  = 1'b0;
    incr_pc = 1'b0;
    W_D     = 1'b0;
    Done    = 1'b0;
    if (active) begin
      case (tstep_q)
        T0: begin
          Rout   = onehot(PC_SEL);
          ADDRin = 1'b1;
        end
        T1: incr_pc = 1'b1;
        T2: IRin = 1'b1;
        T3: begin
          case (opcode)
            OP_MV: begin
              Rout = onehot(ry);
              Rin  = onehot(rx);
              Done = 1'b1;
            end
            OP_MVI: begin
              Rout   = onehot(PC_SEL);
              ADDRin = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Rout = onehot(rx);
              Ain  = 1'b1;
            end
            OP_LD, OP_ST: begin
              Rout   = onehot(ry);
              ADDRin = 1'b1;
            end
            OP_MVNZ: begin
              if (G_nz) begin
                Rout = onehot(ry);
                Rin  = onehot(rx);
              end
              Done = 1'b1;
            end
            default: Done = 1'b1;
          endcase
        end
        T4: begin
          case (opcode)
            OP_MVI: incr_pc = 1'b1;
            OP_ADD: begin
              Rout = onehot(ry);
              Gin  = 1'b1;
            end
            OP_SUB: begin
              Rout   = onehot(ry);
              Gin    = 1'b1;
              AddSub = 1'b1;
            end
            OP_ST: begin
              Rout   = onehot(rx);
              DOUTin = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_MVI, OP_LD: begin
              DINout = 1'b1;
              Rin    = onehot(rx);
            end
            OP_ADD, OP_SUB: begin
              Gout = 1'b1;
              Rin  = onehot(rx);
            end
            OP_ST: W_D = 1'b1;
            default: ;
          endcase
          Done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next step and next instruction: advance while running, wrap on Done.
  always_comb begin
    tstep_d = tstep_q;
    ir_d    = ir_q;
    if (active) begin
      tstep_d = Done ? T0 : step_e'(tstep_q + 3'd1);
    end
    if (IRin) begin
      ir_d = DIN;
    end
  end

  // Step counter and instruction register with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (Reset) begin
      tstep_q <= T0;
      ir_q    <= '0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed instructions from the
// test plan followed by random instructions with random stalls and resets,
// compared cycle by cycle against a per-instruction micro-op list.
module tb_proc_sequencer;

  logic       Clock, Reset, Run, G_nz;
  logic [8:0] DIN;
  logic       IRin, Ain, Gin, Gout, AddSub, DINout, ADDRin, DOUTin;
  logic       incr_pc, W_D, Done;
  logic [7:0] Rin, Rout;
  logic [2:0] Tstep;
  logic [8:0] IR;

  proc_sequencer #(.N(9), .PC_IDX(7)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .G_nz(G_nz),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .AddSub(AddSub), .DINout(DINout), .ADDRin(ADDRin), .DOUTin(DOUTin),
    .incr_pc(incr_pc), .W_D(W_D), .Done(Done), .Tstep(Tstep), .IR(IR)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain, gin, gout, addsub, dinout, addrin, doutin, incr_pc, w_d, done;
  } ctl_t;

  ctl_t dut_ctl;
  assign dut_ctl = {IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout, ADDRin,
                    DOUTin, incr_pc, W_D, Done};

  int   n_tests = 0;
  int   n_fail  = 0;
  ctl_t seq[$];
  logic [8:0] exp_ir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] oh(input int idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  // Micro-op list for one instruction; Done marks the final entry.
  function automatic void build_seq(input logic [8:0] instr, input logic gnz);
    ctl_t c;
    int   op, rx, ry;
    op = int'(instr[2:0]);
    rx = int'(instr[5:3]);
    ry = int'(instr[8:6]);
    seq.delete();
    c = '0; c.rout = oh(7); c.addrin = 1'b1; seq.push_back(c);
    c = '0; c.incr_pc = 1'b1;                seq.push_back(c);
    c = '0; c.irin = 1'b1;                   seq.push_back(c);
    case (op)
      0: begin c = '0; c.rout = oh(ry); c.rin = oh(rx); seq.push_back(c); end
      1: begin
        c = '0; c.rout = oh(7); c.addrin = 1'b1;      seq.push_back(c);
        c = '0; c.incr_pc = 1'b1;                     seq.push_back(c);
        c = '0; c.dinout = 1'b1; c.rin = oh(rx);      seq.push_back(c);
      end
      2, 3: begin
        c = '0; c.rout = oh(rx); c.ain = 1'b1;        seq.push_back(c);
        c = '0; c.rout = oh(ry); c.gin = 1'b1; c.addsub = (op == 3); seq.push_back(c);
        c = '0; c.gout = 1'b1; c.rin = oh(rx);        seq.push_back(c);
      end
      4: begin
        c = '0; c.rout = oh(ry); c.addrin = 1'b1;     seq.push_back(c);
        c = '0;                                       seq.push_back(c);
        c = '0; c.dinout = 1'b1; c.rin = oh(rx);      seq.push_back(c);
      end
      5: begin
        c = '0; c.rout = oh(ry); c.addrin = 1'b1;     seq.push_back(c);
        c = '0; c.rout = oh(rx); c.doutin = 1'b1;     seq.push_back(c);
        c = '0; c.w_d = 1'b1;                         seq.push_back(c);
      end
      6: begin
        c = '0;
        if (gnz) begin c.rout = oh(ry); c.rin = oh(rx); end
        seq.push_back(c);
      end
      default: begin c = '0; seq.push_back(c); end
    endcase
    seq[seq.size()-1].done = 1'b1;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Sample state and enables mid-cycle, after inputs have settled.
  task automatic sample(input string tag, input ctl_t exp_ctl, input int exp_step);
    #1;
    check({tag, " ctl"}, 32'(dut_ctl), 32'(exp_ctl));
    check({tag, " Tstep"}, 32'(Tstep), 32'(exp_step));
    check({tag, " IR"}, 32'(IR), 32'(exp_ir));
  endtask

  // Run one instruction; optional stall before step stall_at and optional
  // reset at step reset_at (which abandons the instruction).
  task automatic run_instr(input logic [8:0] instr, input logic gnz,
                           input int stall_at, input int stall_len, input int reset_at);
    build_seq(instr, gnz);
    DIN  = instr;
    G_nz = gnz;
    for (int idx = 0; idx < seq.size(); idx++) begin
      if (idx == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          Run = 1'b0;
          sample($sformatf("stall op%0d T%0d", instr[2:0], idx), '0, idx);
          tick();
        end
      end
      Run = 1'b1;
      if (idx == reset_at) begin
        Reset = 1'b1;
        sample($sformatf("reset op%0d T%0d", instr[2:0], idx), '0, idx);
        tick();
        Reset  = 1'b0;
        exp_ir = '0;
        return;
      end
      sample($sformatf("op%0d T%0d", instr[2:0], idx), seq[idx], idx);
      tick();
      if (idx == 2) exp_ir = instr;
    end
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b1;
    G_nz  = 1'b0;
    DIN   = 9'h1ff;
    exp_ir = '0;
    tick();
    #1;
    check("reset ctl", 32'(dut_ctl), 32'd0);
    check("reset Tstep", 32'(Tstep), 32'd0);
    check("reset IR", 32'(IR), 32'd0);
    tick();
    Reset = 1'b0;

    run_instr(9'b000_001_001, 1'b0, -1, 0, -1);  // mvi R1
    run_instr(9'b010_001_010, 1'b0, -1, 0, -1);  // add R1,R2
    run_instr(9'b010_001_011, 1'b1, -1, 0, -1);  // sub R1,R2
    run_instr(9'b100_011_110, 1'b0, -1, 0, -1);  // mvnz, G zero
    run_instr(9'b100_011_110, 1'b1, -1, 0, -1);  // mvnz, G non-zero
    run_instr(9'b110_101_101, 1'b0, -1, 0, -1);  // st R5,R6
    run_instr(9'b011_010_100, 1'b0,  4, 3, -1);  // ld with stall at T4
    run_instr(9'b010_001_010, 1'b0, -1, 0,  4);  // add reset at T4
    run_instr(9'b000_111_000, 1'b0, -1, 0, -1);  // mv R7,R0 (jump)
    run_instr(9'b000_000_111, 1'b0, -1, 0, -1);  // reserved nop

    for (int k = 0; k < 300; k++) begin
      logic [8:0] instr;
      int st_at, rs_at;
      instr = 9'($urandom);
      st_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      rs_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(instr, 1'($urandom), st_at, int'($urandom_range(1, 3)), rs_at);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
Multicycle control FSM for the 9-bit processor datapath (R0..R7, A, G, ALU, bus mux, ADDR/DOUT registers, synchronous memory).
- Owns the step counter and the instruction register.
- R7 is the program counter.
- Sequences fetch, then executes mv, mvi, add, sub, ld, st, mvnz.
- Drives every datapath enable; the datapath has no control logic of its own.

Parameters:
N, 9, data/instruction width (instruction format fixed at 9 bits)
PC_IDX, 7, index of the register used as program counter

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  1 = advance one step per clock; 0 = stall
DIN  input  N  memory read data (instruction or operand)
G_nz  input  1  1 when datapath register G is non-zero
IRin  output  1  internal IR load strobe (exported for debug)
Rin  output  8  one-hot register write enables R0..R7
Rout  output  8  one-hot register bus-drive enables R0..R7
Ain  output  1  load A
Gin  output  1  load G
Gout  output  1  G drives bus
AddSub  output  1  1 = ALU subtracts
DINout  output  1  DIN drives bus
ADDRin  output  1  load memory address register from bus
DOUTin  output  1  load memory write-data register from bus
incr_pc  output  1  increment R7
W_D  output  1  memory write enable
Done  output  1  one-cycle pulse on last step of an instruction
Tstep  output  3  current step, 0..5
IR  output  N  current instruction register

Behaviour:
- Clock/reset: single clock `Clock`. `Reset` is synchronous and active-high. When Reset=1 at an edge, Tstep=0 and IR=0.
- Enables under reset or stall: while Reset=1, all enables and Done are 0 in that cycle. While Run=0, all enables and Done are 0.
- Reset mid-instruction: abandons the instruction. The next step is T0.
- Instruction decode: opcode = IR[2:0], Rx = IR[5:3], Ry = IR[8:6]. Rin and Rout are always one-hot or zero.
- Step advance: with Run=1, Tstep advances by one per clock. On the cycle Done=1, Tstep returns to 0. With Run=0, Tstep and IR hold.
- Memory timing: read latency is 1 clock after ADDRin. A stall between steps must not lose data, because ADDR is held.
- Fetch, all opcodes:
  - T0: Rout[PC_IDX], ADDRin.
  - T1: incr_pc.
  - T2: IRin (IR <= DIN at end of T2).
- T3:
  - mv (000): Rout[Ry], Rin[Rx], Done.
  - mvi (001): Rout[PC_IDX], ADDRin.
  - add (010) / sub (011): Rout[Rx], Ain.
  - ld (100) / st (101): Rout[Ry], ADDRin.
  - mvnz (110): if G_nz=1 then Rout[Ry], Rin[Rx]; Done regardless of G_nz.
  - 111: reserved, Done only (nop).
- T4:
  - mvi: incr_pc.
  - add: Rout[Ry], Gin.
  - sub: Rout[Ry], Gin, AddSub.
  - ld: no enables (memory wait).
  - st: Rout[Rx], DOUTin.
- T5:
  - mvi: DINout, Rin[Rx], Done.
  - add/sub: Gout, Rin[Rx], Done.
  - ld: DINout, Rin[Rx], Done.
  - st: W_D, Done.
- Latency in clocks with Run=1: mv/mvnz/nop = 4; mvi/add/sub/ld/st = 6.
- Invariants:
  - At most one bus driver per cycle (Rout, Gout, DINout mutually exclusive).
  - incr_pc is never asserted in the same cycle as Rin[PC_IDX].
- Rx=PC_IDX: allowed; implements a jump.
- Rx=Ry: allowed, no special case.
- Outputs are combinational from Tstep/IR/opcode/G_nz/Run/Reset. Tstep and IR are the only registers, apart from an optional decode register.

Test Plan:
1. Reset, then Run=1, memory word 0 = mvi R1 (IR=9'b000_001_001), word 1 = 5 -> Done at 6th clock; T5 shows DINout=1, Rin=8'b0000_0010; incr_pc pulses in T1 and T4.
2. add R1,R2 (IR=9'b010_001_010) -> T3: Rout=8'b0000_0010, Ain=1; T4: Rout=8'b0000_0100, Gin=1, AddSub=0; T5: Gout=1, Rin=8'b0000_0010, Done=1. For sub (opcode 011), AddSub=1 in T4.
3. mvnz R3,R4 (IR=9'b100_011_110):
   - with G_nz=0 -> T3: Rin=0, Rout=0, Done=1.
   - with G_nz=1 -> T3: Rout=8'b0001_0000, Rin=8'b0000_1000, Done=1.
4. st R5,R6 (IR=9'b110_101_101) -> T3: Rout=8'b0100_0000, ADDRin; T4: Rout=8'b0010_0000, DOUTin; T5: W_D=1, Done=1. Tstep=0 on the following clock.
5. Run dropped to 0 during T4 of ld for 3 clocks -> Tstep holds at 4, all enables 0, no Done. Run=1 resumes T5 with DINout, Rin[Rx], Done.
6. Reset=1 asserted at T4 of add -> same cycle all enables 0. Next clock Tstep=0, IR=0. The following fetch issues Rout[7], ADDRin.
